// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - 50% duty square-wave tone synthesiser driven by a sequencer note code
// Pitch and stop changes are applied only at half-period boundaries so no pulse is ever truncated.
module tone_generator #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_en,
  input  logic [3:0] note_sel,
  output logic       speaker_out,
  output logic       tone_active,
  output logic [3:0] cur_note,
  output logic       cycle_tick
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Code 15 is silence; its slot only pads the table and is never loaded.
  localparam int FREQ [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                               587, 659, 698, 784, 880, 988, 1047, 1047};

  logic [CNT_W-1:0] w_half_tab [16];
  logic [CNT_W-1:0] w_reload;
  logic             w_play;

  for (genvar k = 0; k < 16; k++) begin : g_half
    assign w_half_tab[k] = CNT_W'(CLK_HZ / (2 * FREQ[k]) - 1);
  end

  assign w_play   = sound_en && (note_sel != 4'd15);
  assign w_reload = w_half_tab[note_sel];

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_spk;
  logic             r_active;
  logic [3:0]       r_note;
  logic             r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_spk    <= 1'b0;
      r_active <= 1'b0;
      r_note   <= 4'd0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_spk    <= 1'b0;
          r_active <= 1'b0;
          if (w_play) begin
            r_note   <= note_sel;
            r_cnt    <= w_reload;
            r_spk    <= 1'b1;
            r_tick   <= 1'b1;
            r_active <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_play) begin
            // Boundary: toggle and reload from the (possibly new) note.
            r_spk  <= ~r_spk;
            r_tick <= ~r_spk;
            r_note <= note_sel;
            r_cnt  <= w_reload;
          end else begin
            r_spk    <= 1'b0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign speaker_out = r_spk;
  assign tone_active = r_active;
  assign cur_note    = r_note;
  assign cycle_tick  = r_tick;

endmodule

// File: tb/tb_tone_generator.sv
// tb/tb_tone_generator.sv - self-checking bench for tone_generator
// Model tracks absolute boundary deadlines; directed steps pin literal half-period lengths.
module tb_tone_generator;

  localparam int CLK_HZ = 8_000_000;
  localparam int FREQ [15] = '{262, 294, 330, 349, 392, 440, 494, 523,
                               587, 659, 698, 784, 880, 988, 1047};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sound_en = 1'b0;
  logic [3:0] note_sel = 4'd0;
  logic       speaker_out;
  logic       tone_active;
  logic [3:0] cur_note;
  logic       cycle_tick;

  int checks = 0;
  int errors = 0;

  tone_generator #(.CLK_HZ(CLK_HZ), .CNT_W(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .sound_en    (sound_en),
    .note_sel    (note_sel),
    .speaker_out (speaker_out),
    .tone_active (tone_active),
    .cur_note    (cur_note),
    .cycle_tick  (cycle_tick)
  );

  always #5 clk = ~clk;

  function automatic int half(input int n);
    return CLK_HZ / (2 * FREQ[n]);
  endfunction

  // Model: a half-period that starts on edge c ends on edge c + half(note).
  bit         m_spk = 1'b0;
  bit         m_act = 1'b0;
  bit         m_tick = 1'b0;
  logic [3:0] m_note = 4'd0;
  longint     cyc = 0;
  longint     m_end = 0;
  bit         m_play;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_spk = 1'b0; m_act = 1'b0; m_tick = 1'b0; m_note = 4'd0;
      end else begin
        cyc++;
        m_tick = 1'b0;
        m_play = sound_en && (note_sel != 4'd15);
        if (!m_act) begin
          if (m_play) begin
            m_act = 1'b1; m_spk = 1'b1; m_tick = 1'b1;
            m_note = note_sel;
            m_end = cyc + half(int'(note_sel));
          end
        end else if (cyc == m_end) begin
          if (m_play) begin
            m_note = note_sel;
            m_spk = !m_spk;
            m_tick = m_spk;
            m_end = cyc + half(int'(note_sel));
          end else begin
            m_act = 1'b0; m_spk = 1'b0;
          end
        end
      end
    end
  end

  logic [6:0] exp_v, act_v;
  initial begin
    forever begin
      @(negedge clk);
      exp_v = {m_spk, m_act, m_tick, (m_act ? m_note : 4'd0)};
      act_v = {speaker_out, tone_active, cycle_tick, (tone_active ? cur_note : 4'd0)};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t spk/act/tick/note got %b expected %b", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_sig(input int sel, input logic v, input int budget, output int n);
    n = 0;
    while ((((sel == 0) ? speaker_out : tone_active) !== v) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  int n;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_spk", speaker_out, 0);
    check("rst_act", tone_active, 0);
    check("rst_tick", cycle_tick, 0);
    check("rst_note", cur_note, 0);
    reset = 1'b0;
    cycles(2);

    // A4 from idle
    sound_en = 1'b1; note_sel = 4'd5;
    @(negedge clk);
    check("s1_rise", speaker_out, 1);
    check("s1_tick0", cycle_tick, 1);
    check("s1_act", tone_active, 1);
    check("s1_note", cur_note, 5);
    check("model_half_a4", half(5), 9090);
    wait_sig(0, 1'b0, 20000, n); check("s1_high", n, 9090);
    wait_sig(0, 1'b1, 20000, n); check("s1_low", n, 9090);
    check("s1_tick1", cycle_tick, 1);
    @(negedge clk);
    check("s1_tick_pulse", cycle_tick, 0);

    // switch to C6 mid-half
    cycles(1999); note_sel = 4'd14;
    check("s2_note_hold", cur_note, 5);
    wait_sig(0, 1'b0, 20000, n); check("s2_a4_tail", n, 7090);
    check("s2_note", cur_note, 14);
    wait_sig(0, 1'b1, 20000, n); check("s2_c6_low", n, 3820);
    sound_en = 1'b0;
    wait_sig(0, 1'b0, 20000, n); check("s2_c6_high", n, 3820);
    check("s2_stop", tone_active, 0);
    cycles(200);
    check("s2_idle", speaker_out, 0);

    // E4 with a short rest inside the half-period
    note_sel = 4'd2; sound_en = 1'b1;
    @(negedge clk);
    check("s4_rise", speaker_out, 1);
    cycles(3000); sound_en = 1'b0;
    cycles(100);  sound_en = 1'b1;
    wait_sig(0, 1'b0, 20000, n); check("s4_high", n, 9021);
    wait_sig(0, 1'b1, 20000, n); check("s4_low", n, 12121);

    // asynchronous reset mid-high
    cycles(1000);
    #2 reset = 1'b1;
    #1;
    check("s6_spk", speaker_out, 0);
    check("s6_act", tone_active, 0);
    check("s6_tick", cycle_tick, 0);
    @(negedge clk);
    note_sel = 4'd5;
    cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check("s6_rise", speaker_out, 1);
    wait_sig(0, 1'b0, 20000, n); check("s6_high", n, 9090);

    // code 15 is silence, then C4
    #2 reset = 1'b1; note_sel = 4'd15;
    @(negedge clk);
    cycles(1);
    reset = 1'b0;
    cycles(50);
    check("s5_idle_spk", speaker_out, 0);
    check("s5_idle_act", tone_active, 0);
    note_sel = 4'd0;
    @(negedge clk);
    check("s5_rise", speaker_out, 1);
    check("s5_note", cur_note, 0);
    check("model_half_c4", half(0), 15267);

    // stop while high: the high half still completes
    cycles(5000); sound_en = 1'b0;
    wait_sig(0, 1'b0, 20000, n); check("s3_high_tail", n, 10267);
    check("s3_act", tone_active, 0);
    cycles(500);
    check("s3_hold_spk", speaker_out, 0);
    check("s3_hold_act", tone_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
